// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
// Contents: controller state encoding, default register-index width,
// flush-counter width and the NOP encoding the pipeline registers load on flush.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

    localparam int REG_W_DEF   = 5;
    // FLUSH_CYCLES is limited to 1..7, so 3 bits hold any reload value.
    localparam int FLUSH_CNT_W = 3;

    // addi x0, x0, 0 - what a flushed pipeline register presents downstream.
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [2:0]  NOP_IMMSRC = 3'd0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
// Ports: d_rs1/d_rs2 decode sources, e_rd execute destination,
// e_is_load execute holds a load, load_use hazard flag.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] d_rs1,
    input  logic [REG_W-1:0] d_rs2,
    input  logic [REG_W-1:0] e_rd,
    input  logic             e_is_load,
    output logic             load_use
);

    // x0 is never really written, so a load targeting it cannot cause a hazard.
    assign load_use = e_is_load & (e_rd != '0) & ((e_rd == d_rs1) | (e_rd == d_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the segmented RV32 pipeline
// Inputs: clk, rst (sync active-low), decode sources, execute rd/load/pcsrc,
// memory-stage request/ready. Outputs: PC and four pipeline-register enables,
// fetch/decode and decode/execute flushes, saturating stall-cycle counter.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] d_rs1,
    input  logic [REG_W-1:0] d_rs2,
    input  logic [REG_W-1:0] e_rd,
    input  logic             e_is_load,
    input  logic             e_pcsrc,
    input  logic             m_mem_req,
    input  logic             m_mem_ready,
    output logic             pc_enable,
    output logic             fd_enable,
    output logic             de_enable,
    output logic             em_enable,
    output logic             mw_enable,
    output logic             fd_flush,
    output logic             de_flush,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [FLUSH_CNT_W-1:0] RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    hz_state_t              state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]       stall_count_q, stall_count_d;

    logic mem_wait;
    logic load_use;

    assign mem_wait = m_mem_req & ~m_mem_ready;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .d_rs1     (d_rs1),
        .d_rs2     (d_rs2),
        .e_rd      (e_rd),
        .e_is_load (e_is_load),
        .load_use  (load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // MEM_WAIT has no behaviour of its own once the access completes: the
    // release cycle is handled exactly like RUN, so a branch frozen in E fires then.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_wait) begin
            // A freeze inside a flush window keeps the window and its count intact.
            if (state_q != FLUSH) begin
                state_d = MEM_WAIT;
            end
        end else if (e_pcsrc) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = RELOAD;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == FLUSH) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= FLUSH_CNT_W'(1)) begin
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_comb begin
        pc_enable = 1'b1;
        fd_enable = 1'b1;
        de_enable = 1'b1;
        em_enable = 1'b1;
        mw_enable = 1'b1;
        fd_flush  = 1'b0;
        de_flush  = 1'b0;
        if (!rst) begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            de_enable = 1'b0;
            em_enable = 1'b0;
            mw_enable = 1'b0;
            fd_flush  = 1'b1;
            de_flush  = 1'b1;
        end else if (mem_wait) begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            de_enable = 1'b0;
            em_enable = 1'b0;
            mw_enable = 1'b0;
        end else if (e_pcsrc) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (state_q == FLUSH) begin
            fd_flush = 1'b1;
        end else if (load_use) begin
            // Hold F and D, inject a bubble into E; the load moves on to M.
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            de_flush  = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_enable && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int FC  = 2;
    localparam int CW  = 4;
    localparam int RW  = 5;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [RW-1:0] d_rs1 = '0, d_rs2 = '0, e_rd = '0;
    logic          e_is_load = 1'b0, e_pcsrc = 1'b0;
    logic          m_mem_req = 1'b0, m_mem_ready = 1'b0;
    logic          pc_enable, fd_enable, de_enable, em_enable, mw_enable;
    logic          fd_flush, de_flush;
    logic [CW-1:0] stall_count;

    int tests = 0;
    int fails = 0;

    // Model state: remaining fd_flush cycles owed after a redirect, and stall total.
    int m_flush_left = 0;
    int m_stalls     = 0;

    pipe_hazard_ctrl #(
        .REG_W        (RW),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d_rs1       (d_rs1),
        .d_rs2       (d_rs2),
        .e_rd        (e_rd),
        .e_is_load   (e_is_load),
        .e_pcsrc     (e_pcsrc),
        .m_mem_req   (m_mem_req),
        .m_mem_ready (m_mem_ready),
        .pc_enable   (pc_enable),
        .fd_enable   (fd_enable),
        .de_enable   (de_enable),
        .em_enable   (em_enable),
        .mw_enable   (mw_enable),
        .fd_flush    (fd_flush),
        .de_flush    (de_flush),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit mw, lu;
        logic [4:0] e_en;
        logic [1:0] e_fl;
        mw = m_mem_req && !m_mem_ready;
        lu = e_is_load && (e_rd != 0) && ((e_rd == d_rs1) || (e_rd == d_rs2));
        if (!rst) begin
            e_en = 5'b00000; e_fl = 2'b11;
        end else if (mw) begin
            e_en = 5'b00000; e_fl = 2'b00;
        end else if (e_pcsrc) begin
            e_en = 5'b11111; e_fl = 2'b11;
        end else if (m_flush_left > 0) begin
            e_en = 5'b11111; e_fl = 2'b10;
        end else if (lu) begin
            e_en = 5'b00111; e_fl = 2'b01;
        end else begin
            e_en = 5'b11111; e_fl = 2'b00;
        end
        chk("model_enables", {pc_enable, fd_enable, de_enable, em_enable, mw_enable}, e_en);
        chk("model_flushes", {fd_flush, de_flush}, e_fl);
        chk("model_stall_count", stall_count, m_stalls);
        if (!rst) begin
            m_flush_left = 0;
            m_stalls     = 0;
        end else begin
            if (!mw) begin
                if (e_pcsrc) m_flush_left = FC - 1;
                else if (m_flush_left > 0) m_flush_left--;
            end
            if (!e_en[4] && m_stalls < SAT) m_stalls++;
        end
    end

    task automatic drive(input bit r, input bit pcsrc, input bit req, input bit rdy,
                         input bit ld, input int rd, input int rs1, input int rs2);
        @(posedge clk);
        #1;
        rst         = r;
        e_pcsrc     = pcsrc;
        m_mem_req   = req;
        m_mem_ready = rdy;
        e_is_load   = ld;
        e_rd        = RW'(rd);
        d_rs1       = RW'(rs1);
        d_rs2       = RW'(rs2);
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 1, 2);
    endtask

    function automatic logic [4:0] en_vec();
        return {pc_enable, fd_enable, de_enable, em_enable, mw_enable};
    endfunction

    initial begin
        // Reset with arbitrary inputs.
        e_pcsrc = 1'b0; m_mem_req = 1'b1; m_mem_ready = 1'b0;
        e_is_load = 1'b1; e_rd = 5'd4; d_rs1 = 5'd4;
        @(negedge clk);
        chk("reset_enables", en_vec(), 5'b00000);
        chk("reset_flushes", {fd_flush, de_flush}, 2'b11);
        drive(0, 1, 1, 1, 1, 9, 9, 3);
        @(negedge clk);
        chk("reset2_enables", en_vec(), 5'b00000);
        idle();
        @(negedge clk);
        chk("post_reset_enables", en_vec(), 5'b11111);
        chk("post_reset_flushes", {fd_flush, de_flush}, 2'b00);
        chk("post_reset_stall", stall_count, 0);

        // Load-use on rs2.
        drive(1, 0, 0, 0, 1, 5, 3, 5);
        @(negedge clk);
        chk("lu_enables", en_vec(), 5'b00111);
        chk("lu_de_flush", de_flush, 1);
        idle();
        @(negedge clk);
        chk("lu_after_pc", pc_enable, 1);
        chk("lu_stall_count", stall_count, 1);
        // Load to x0 never stalls.
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("lu_x0_enables", en_vec(), 5'b11111);
        chk("lu_x0_de_flush", de_flush, 0);

        // Branch coinciding with a load-use: redirect wins.
        drive(1, 1, 0, 0, 1, 5, 5, 2);
        @(negedge clk);
        chk("br_flushes", {fd_flush, de_flush}, 2'b11);
        chk("br_enables", en_vec(), 5'b11111);
        drive(1, 0, 0, 0, 1, 7, 7, 0);
        @(negedge clk);
        chk("br2_flushes", {fd_flush, de_flush}, 2'b10);
        chk("br2_pc", pc_enable, 1);
        idle();
        @(negedge clk);
        chk("br3_flushes", {fd_flush, de_flush}, 2'b00);
        chk("br_stall_count", stall_count, 1);

        // Three-cycle memory wait then release.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 0, 0, 1, 2);
            @(negedge clk);
            chk("mw_enables", en_vec(), 5'b00000);
            chk("mw_flushes", {fd_flush, de_flush}, 2'b00);
        end
        drive(1, 0, 1, 1, 0, 0, 1, 2);
        @(negedge clk);
        chk("mw_release_enables", en_vec(), 5'b11111);
        idle();
        @(negedge clk);
        chk("mw_stall_count", stall_count, 4);

        // Branch frozen in E during a two-cycle wait.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 0, 0, 0, 1, 2);
            @(negedge clk);
            chk("frz_flushes", {fd_flush, de_flush}, 2'b00);
            chk("frz_enables", en_vec(), 5'b00000);
        end
        drive(1, 1, 1, 1, 0, 0, 1, 2);
        @(negedge clk);
        chk("frz_release_flushes", {fd_flush, de_flush}, 2'b11);
        chk("frz_release_enables", en_vec(), 5'b11111);
        idle();
        @(negedge clk);
        chk("frz_window_flushes", {fd_flush, de_flush}, 2'b10);
        idle();
        @(negedge clk);
        chk("frz_done_flushes", {fd_flush, de_flush}, 2'b00);
        chk("frz_stall_count", stall_count, 6);

        // Memory wait inside a flush window holds the window.
        drive(1, 1, 0, 0, 0, 0, 1, 2);
        drive(1, 0, 1, 0, 0, 0, 1, 2);
        @(negedge clk);
        chk("fw_freeze_flushes", {fd_flush, de_flush}, 2'b00);
        drive(1, 0, 1, 1, 0, 0, 1, 2);
        @(negedge clk);
        chk("fw_resume_flushes", {fd_flush, de_flush}, 2'b10);
        idle();
        @(negedge clk);
        chk("fw_done_flushes", {fd_flush, de_flush}, 2'b00);
        chk("fw_stall_count", stall_count, 7);

        // Reset in the middle of a flush window.
        drive(1, 1, 0, 0, 0, 0, 1, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        @(negedge clk);
        chk("midrst_flushes", {fd_flush, de_flush}, 2'b11);
        chk("midrst_enables", en_vec(), 5'b00000);
        idle();
        @(negedge clk);
        chk("midrst_after_flushes", {fd_flush, de_flush}, 2'b00);
        chk("midrst_stall_count", stall_count, 0);

        // Saturation: 20 stall cycles on a 4-bit counter.
        for (int i = 0; i < 20; i++) drive(1, 0, 1, 0, 0, 0, 1, 2);
        idle();
        @(negedge clk);
        chk("sat_stall_count", stall_count, SAT);

        // Mixed pseudo-random traffic; the compare process checks every cycle.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        idle();
        idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the segmented RV32 pipeline. It drives the enable and flush inputs of the fetch/decode, decode/execute, execute/memory and memory/writeback pipeline registers, including de_immsrc. It resolves three hazard classes:
- load-use hazards
- taken-branch/jump redirects
- multi-cycle data-memory waits

A small FSM sequences freeze and multi-cycle flush windows.

Parameters:
REG_W, 5, register-index width
FLUSH_CYCLES, 1, number of cycles fd_flush stays asserted after a redirect (range 1..7; use 2 for a registered imem)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  reset; synchronous, active-low
d_rs1  input  REG_W  rs1 of the instruction in decode
d_rs2  input  REG_W  rs2 of the instruction in decode
e_rd  input  REG_W  rd of the instruction in execute
e_is_load  input  1  instruction in execute is a load
e_pcsrc  input  1  branch taken / jump in execute
m_mem_req  input  1  memory stage has an active dmem access
m_mem_ready  input  1  dmem access completes this cycle
pc_enable  output  1  PC register enable
fd_enable  output  1  fetch/decode register enable
de_enable  output  1  decode/execute register enable
em_enable  output  1  execute/memory register enable
mw_enable  output  1  memory/writeback register enable
fd_flush  output  1  clear fetch/decode register to NOP
de_flush  output  1  clear decode/execute register to NOP
stall_count  output  CNT_W  cycles with pc_enable=0, saturating

Behaviour:
- Reset is synchronous, active-low. On a clk edge with rst=0: state<=RUN, flush counter<=0, stall_count<=0.
- While rst=0, outputs are forced combinationally: all enables=0, fd_flush=1, de_flush=1.
- All other outputs are combinational from state and current inputs (zero latency). State, flush counter and stall_count update on the rising edge.
- Definitions:
  - mem_wait = m_mem_req & ~m_mem_ready
  - load_use = e_is_load & (e_rd!=0) & (e_rd==d_rs1 | e_rd==d_rs2)
- Priority: mem_wait > redirect (e_pcsrc or FLUSH state) > load_use > normal.
- Defaults: all enables=1, flushes=0.
- State RUN:
  - mem_wait: all five enables=0, no flush. Next state MEM_WAIT.
  - else e_pcsrc: fd_flush=1, de_flush=1, enables=1. If FLUSH_CYCLES>1: next state FLUSH, cnt<=FLUSH_CYCLES-1. Else stay RUN.
  - else load_use: pc_enable=0, fd_enable=0, de_flush=1; E/M/W enables=1. One bubble per hazard; the next cycle re-evaluates with the load now in M.
  - else: normal.
- State MEM_WAIT:
  - while mem_wait: full freeze as above.
  - when m_mem_ready=1 (or m_mem_req drops): evaluate exactly as RUN with mem_wait=0, including e_pcsrc and load_use. A branch frozen in E acts on the release cycle. Next state per RUN rules.
- State FLUSH:
  - fd_flush=1, enables=1; cnt decrements. At cnt==1 the next state is RUN.
  - mem_wait in FLUSH: full freeze, fd_flush=0, cnt held, state held.
  - a new e_pcsrc in FLUSH: de_flush=1 and cnt reloads to FLUSH_CYCLES-1.
- stall_count increments on each cycle where pc_enable=0 and rst=1. It holds at all-ones (no wrap).
- e_rd==0 never produces a load-use stall.
- A simultaneous rs1/rs2 match gives a single bubble.
- A mid-operation reset (rst=0 in any state) aborts to RUN next edge and discards the flush counter.

Decomposition:
- Shared package hazard_pkg:
  - state enum hz_state_t {RUN, MEM_WAIT, FLUSH} (2 bits)
  - REG_W default localparam
  - NOP-related constants shared with the pipeline registers
- Sub-module load_use_detect: combinational comparator producing load_use from d_rs1/d_rs2/e_rd/e_is_load.
- The FSM, flush counter and stall counter stay in pipe_hazard_ctrl.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> enables=0, flushes=1. After release: state RUN, stall_count=0, all enables=1.
- Load-use: e_is_load=1, e_rd=5, d_rs2=5 for one cycle -> pc_enable=0, fd_enable=0, de_flush=1 for exactly that cycle, then stall_count=1. Same stimulus with e_rd=0 -> no stall.
- Branch with FLUSH_CYCLES=2: e_pcsrc pulse -> fd_flush=1 for 2 consecutive cycles, de_flush=1 only in the first. Same cycle as load_use=1 -> no pc stall.
- Memory wait: m_mem_req=1, m_mem_ready=0 for 3 cycles, then ready=1 -> all enables=0 for 3 cycles, enables=1 on the ready cycle, stall_count=3.
- Frozen branch: e_pcsrc=1 held during a 2-cycle mem_wait -> no flush while frozen. fd_flush=de_flush=1 on the release cycle.
- Saturation and mid-op reset with CNT_W=4: 20 stall cycles -> stall_count=15. Drop rst in FLUSH -> RUN and counter 0 after the edge.
